// File: rtl/pll_reconfig_pkg.sv
// Shared types and register map for the PLL reconfiguration sequencer.
//   seq_state_t : sequencer state encoding
//   REG_*       : pll_cfg management register addresses
package pll_reconfig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_M_WR,
        ST_K_WR,
        ST_START,
        ST_WAIT_LOCK,
        ST_FIN
    } seq_state_t;

    localparam logic [5:0] REG_MODE  = 6'd0;
    localparam logic [5:0] REG_START = 6'd2;
    localparam logic [5:0] REG_M     = 6'd4;
    localparam logic [5:0] REG_K     = 6'd7;

endpackage

// File: rtl/pll_reconfig_seq_sel_settle.sv
// sel_settle: 2-flop synchroniser followed by a stability counter.
//   clk        : clock
//   reset      : synchronous, active-high
//   din        : asynchronous input word
//   stable_val : synchronised value
//   stable_vld : high once stable_val has been unchanged for SETTLE cycles
module sel_settle
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned W      = 1,
    parameter int unsigned SETTLE = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] stable_val,
    output logic         stable_vld
);

    localparam int unsigned CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    logic [W-1:0]     meta;
    logic [W-1:0]     sync;
    logic [CNT_W-1:0] cnt;

    // cnt restarts on the very edge where sync takes a new value, so it
    // counts the cycles sync has held its current value.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
            cnt  <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            if (meta != sync) begin
                cnt <= '0;
            end else if (cnt != CNT_W'(SETTLE)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign stable_val = sync;
    assign stable_vld = (cnt == CNT_W'(SETTLE));

endmodule

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: drives the pll_cfg Avalon-MM management port to switch
// the PLL between NUM_PRESETS fractional presets.
//   CLK_50M          : clock
//   reset            : synchronous, active-high
//   preset_sel       : requested preset (asynchronous)
//   pll_locked       : PLL lock indicator (asynchronous)
//   mgmt_waitrequest : Avalon waitrequest from pll_cfg
//   mgmt_write       : Avalon write strobe
//   mgmt_address     : register address
//   mgmt_writedata   : register data
//   busy             : sequence in progress
//   done             : one-cycle pulse at sequence end
//   timeout_err      : sticky lock-timeout flag, cleared at next sequence start
//   active_preset    : preset most recently applied / being applied
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int                          NUM_PRESETS  = 2,
    parameter int                          SEL_W        = $clog2(NUM_PRESETS),
    parameter logic [NUM_PRESETS*32-1:0]   PRESET_K     = {32'd3268298314, 32'd3639383488},
    parameter logic [NUM_PRESETS*32-1:0]   PRESET_M     = {NUM_PRESETS{32'h0000_0808}},
    parameter bit                          FRAC_ONLY    = 1'b1,
    parameter int unsigned                 SETTLE       = 2,
    parameter int unsigned                 GAP          = 3,
    parameter int unsigned                 LOCK_TIMEOUT = 65535
) (
    input  logic             CLK_50M,
    input  logic             reset,
    input  logic [SEL_W-1:0] preset_sel,
    input  logic             pll_locked,
    input  logic             mgmt_waitrequest,
    output logic             mgmt_write,
    output logic [5:0]       mgmt_address,
    output logic [31:0]      mgmt_writedata,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [SEL_W-1:0] active_preset
);

    localparam int unsigned    GAP_W     = (GAP < 2) ? 1 : $clog2(GAP);
    localparam int unsigned    GAP_LAST  = (GAP == 0) ? 0 : GAP - 1;
    localparam int unsigned    LOCK_W    = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT);
    localparam int unsigned    LOCK_LAST = (LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1;
    localparam logic [SEL_W:0] NUM_SEL   = (SEL_W + 1)'(NUM_PRESETS);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [SEL_W-1:0]  stable_val;
    logic              stable_vld;
    logic              lock_meta;
    logic              lock_sync;
    logic              in_gap;
    logic [GAP_W-1:0]  gap_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              req;
    logic              accept;
    logic              step;
    logic              lock_expired;

    sel_settle #(
        .W      (SEL_W),
        .SETTLE (SETTLE)
    ) u_sel_settle (
        .clk        (CLK_50M),
        .reset      (reset),
        .din        (preset_sel),
        .stable_val (stable_val),
        .stable_vld (stable_vld)
    );

    assign req    = stable_vld && ({1'b0, stable_val} < NUM_SEL) && (stable_val != active_preset);
    assign accept = mgmt_write && !mgmt_waitrequest;
    // A write state advances once its write is accepted and the gap has elapsed.
    assign step   = (GAP == 0) ? accept : (in_gap && (gap_cnt == GAP_W'(GAP_LAST)));
    // A lock seen in the final counted cycle still wins over the timeout.
    assign lock_expired = (state == ST_WAIT_LOCK) && !lock_sync &&
                          (lock_cnt == LOCK_W'(LOCK_LAST));

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:      if (req)    state_nxt = ST_MODE;
            ST_MODE:      if (step)   state_nxt = FRAC_ONLY ? ST_K_WR : ST_M_WR;
            ST_M_WR:      if (step)   state_nxt = ST_K_WR;
            ST_K_WR:      if (step)   state_nxt = ST_START;
            ST_START:     if (accept) state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (lock_sync || lock_expired) state_nxt = ST_FIN;
            ST_FIN:       state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mgmt_write     = 1'b0;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        busy           = 1'b0;
        done           = 1'b0;
        unique case (state)
            ST_MODE: begin
                mgmt_write   = !in_gap;
                mgmt_address = REG_MODE;
                busy         = 1'b1;
            end
            ST_M_WR: begin
                mgmt_write     = !in_gap;
                mgmt_address   = REG_M;
                mgmt_writedata = PRESET_M[{active_preset, 5'd0} +: 32];
                busy           = 1'b1;
            end
            ST_K_WR: begin
                mgmt_write     = !in_gap;
                mgmt_address   = REG_K;
                mgmt_writedata = PRESET_K[{active_preset, 5'd0} +: 32];
                busy           = 1'b1;
            end
            ST_START: begin
                mgmt_write   = 1'b1;
                mgmt_address = REG_START;
                busy         = 1'b1;
            end
            ST_WAIT_LOCK: busy = 1'b1;
            ST_FIN:       done = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            lock_meta     <= 1'b0;
            lock_sync     <= 1'b0;
            in_gap        <= 1'b0;
            gap_cnt       <= '0;
            lock_cnt      <= '0;
            active_preset <= '0;
            timeout_err   <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;

            if (state != state_nxt) begin
                in_gap  <= 1'b0;
                gap_cnt <= '0;
            end else if (accept) begin
                in_gap  <= 1'b1;
                gap_cnt <= '0;
            end else if (in_gap) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end

            lock_cnt <= (state == ST_WAIT_LOCK) ? lock_cnt + LOCK_W'(1) : '0;

            if (state == ST_IDLE && req) begin
                active_preset <= stable_val;
                timeout_err   <= 1'b0;
            end else if (lock_expired) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
